// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS ALU control and multiply/divide unit.
// MDU_DIV_EN adds the DIV sequencer state; without it only MUL is present.
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_FIX  = 2'd2
`ifdef MDU_DIV_EN
        , MD_DIV = 2'd3
`endif
    } md_state_t;

    function automatic logic is_md_funct(input logic [5:0] f);
        return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer with the HI/LO registers.
// Divider datapath and DIV state exist only when MDU_DIV_EN is defined.
module mdu_seq
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_mul,
`ifdef MDU_DIV_EN
    input  logic              start_div,
`endif
    input  logic              signed_op,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] acc_reg, q_reg, opb_reg, hi_reg, lo_reg;
    logic              neg_q_reg;

    logic              start_any;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   mul_sum;
    logic [2*DATA_W-1:0] prod_mag, prod_fix;

`ifdef MDU_DIV_EN
    logic              neg_r_reg, divz_reg, is_div_reg;
    logic [DATA_W:0]   div_shift, div_diff;

    assign start_any = start_mul | start_div;
    assign div_shift = {acc_reg, q_reg[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, opb_reg};
`else
    assign start_any = start_mul;
`endif

    // Both operations iterate on magnitudes; signs are reapplied in FIX.
    assign a_neg = signed_op & op_a[DATA_W-1];
    assign b_neg = signed_op & op_b[DATA_W-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    assign mul_sum  = {1'b0, acc_reg} + {1'b0, {DATA_W{q_reg[0]}} & opb_reg};
    assign prod_mag = {acc_reg, q_reg};
    assign prod_fix = neg_q_reg ? -prod_mag : prod_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= MD_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MD_IDLE: begin
                if (start_mul) state_next = MD_MUL;
`ifdef MDU_DIV_EN
                if (start_div) state_next = MD_DIV;
`endif
            end
            MD_MUL:  if (cnt_reg == CNT_ONE) state_next = MD_FIX;
`ifdef MDU_DIV_EN
            MD_DIV:  if (cnt_reg == CNT_ONE) state_next = MD_FIX;
`endif
            MD_FIX:  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            q_reg      <= '0;
            opb_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            neg_q_reg  <= 1'b0;
`ifdef MDU_DIV_EN
            neg_r_reg  <= 1'b0;
            divz_reg   <= 1'b0;
            is_div_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    // Multiplier and dividend share q_reg; multiplicand and divisor share opb_reg.
                    if (start_any) begin
                        cnt_reg    <= CNT_LOAD;
                        acc_reg    <= '0;
                        q_reg      <= a_mag;
                        opb_reg    <= b_mag;
                        neg_q_reg  <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                        neg_r_reg  <= a_neg;
                        divz_reg   <= (op_b == '0);
                        is_div_reg <= start_div;
`endif
                    end
                    if (wr_hi) hi_reg <= op_a;
                    if (wr_lo) lo_reg <= op_a;
                end
                MD_MUL: begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                    acc_reg <= mul_sum[DATA_W:1];
                    q_reg   <= {mul_sum[0], q_reg[DATA_W-1:1]};
                end
`ifdef MDU_DIV_EN
                MD_DIV: begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                    if (!div_diff[DATA_W]) begin
                        acc_reg <= div_diff[DATA_W-1:0];
                        q_reg   <= {q_reg[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_reg <= div_shift[DATA_W-1:0];
                        q_reg   <= {q_reg[DATA_W-2:0], 1'b0};
                    end
                end
`endif
                MD_FIX: begin
`ifdef MDU_DIV_EN
                    // A zero divisor leaves the dividend magnitude in acc_reg, so HI restores rs.
                    if (is_div_reg) begin
                        hi_reg <= neg_r_reg ? -acc_reg : acc_reg;
                        lo_reg <= divz_reg ? '1 : (neg_q_reg ? -q_reg : q_reg);
                    end else
`endif
                    begin
                        hi_reg <= prod_fix[2*DATA_W-1:DATA_W];
                        lo_reg <= prod_fix[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != MD_IDLE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: rtl/alu_control_mdu.sv
// MIPS ALU control decode plus HI/LO multiply/divide issue and stall logic.
// Divide support is compiled in with MDU_DIV_EN; otherwise div/divu are no-ops.
module alu_control_mdu
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        funct,
    input  logic              issue_valid,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [3:0]        ALUCtrl,
    output logic              md_stall,
    output logic              mdu_busy,
    output logic              hilo_sel,
    output logic [DATA_W-1:0] hilo_rdata
);

    logic [3:0]        alu_dec;
    logic              md_class, md_accept;
    logic              start_mul, wr_hi, wr_lo, is_mf;
    logic [DATA_W-1:0] hi, lo;

    always_comb begin
        alu_dec = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: alu_dec = ALU_ADD;
            ALUOP_SUB: alu_dec = ALU_SUB;
            ALUOP_OR:  alu_dec = ALU_OR;
            default: begin
                case (funct)
                    F_ADD, F_ADDU: alu_dec = ALU_ADD;
                    F_SUB, F_SUBU: alu_dec = ALU_SUB;
                    F_AND:         alu_dec = ALU_AND;
                    F_OR:          alu_dec = ALU_OR;
                    F_NOR:         alu_dec = ALU_NOR;
                    F_SLT:         alu_dec = ALU_SLT;
                    F_SLTU:        alu_dec = ALU_SLTU;
                    default:       alu_dec = ALU_ADD;
                endcase
            end
        endcase
    end

    // Outputs read as idle (AND, no select) while reset is held.
    assign ALUCtrl = rst_n ? alu_dec : ALU_AND;

    assign md_class  = (ALUOp == ALUOP_RTYPE) && is_md_funct(funct);
    assign md_stall  = issue_valid & md_class & mdu_busy;
    assign md_accept = issue_valid & md_class & ~mdu_busy;

    assign start_mul = md_accept & ((funct == F_MULT) | (funct == F_MULTU));
    assign wr_hi     = md_accept & (funct == F_MTHI);
    assign wr_lo     = md_accept & (funct == F_MTLO);
    assign is_mf     = (funct == F_MFHI) | (funct == F_MFLO);

`ifdef MDU_DIV_EN
    logic start_div;
    assign start_div = md_accept & ((funct == F_DIV) | (funct == F_DIVU));
`endif

    assign hilo_sel   = rst_n & md_accept & is_mf;
    assign hilo_rdata = !hilo_sel ? '0 : ((funct == F_MFHI) ? hi : lo);

    mdu_seq #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_mdu_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_mul (start_mul),
`ifdef MDU_DIV_EN
        .start_div (start_div),
`endif
        .signed_op (~funct[0]),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .op_a      (rs_data),
        .op_b      (rt_data),
        .busy      (mdu_busy),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu with a cycle-level HI/LO reference model.
`timescale 1ns/1ps
module tb_alu_control_mdu;
    import mips_alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   ALUOp;
    logic [5:0]   funct;
    logic         issue_valid;
    logic [W-1:0] rs_data, rt_data;
    logic [3:0]   ALUCtrl;
    logic         md_stall, mdu_busy, hilo_sel;
    logic [W-1:0] hilo_rdata;

    int checks = 0;
    int errors = 0;

    alu_control_mdu #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ALUOp       (ALUOp),
        .funct       (funct),
        .issue_valid (issue_valid),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .ALUCtrl     (ALUCtrl),
        .md_stall    (md_stall),
        .mdu_busy    (mdu_busy),
        .hilo_sel    (hilo_sel),
        .hilo_rdata  (hilo_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] exp_alu(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (f)
            6'b100000, 6'b100001: return 4'b0010;
            6'b100010, 6'b100011: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            6'b101011: return 4'b0011;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic logic is_md(input logic [5:0] f);
        return f inside {6'b010000, 6'b010001, 6'b010010, 6'b010011,
                         6'b011000, 6'b011001, 6'b011010, 6'b011011};
    endfunction

    function automatic logic [63:0] mult_result(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sp;
        if (sgn) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return 64'(sp);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [63:0] div_result(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] q, r;
        int sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sgn) begin
            sa = $signed(a); sb = $signed(b);
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a; r = 32'd0;
            end else begin
                q = 32'(sa / sb); r = 32'(sa % sb);
            end
        end else begin
            q = a / b; r = a % b;
        end
        return {r, q};
    endfunction

    int           m_left;
    logic [W-1:0] m_hi, m_lo;
    logic [63:0]  m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_res  <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
        end else if (issue_valid && ALUOp == 2'b10 && is_md(funct)) begin
            case (funct)
                6'b010001: m_hi <= rs_data;
                6'b010011: m_lo <= rs_data;
                6'b011000, 6'b011001: begin
                    m_res  <= mult_result(rs_data, rt_data, ~funct[0]);
                    m_left <= W + 1;
                end
`ifdef MDU_DIV_EN
                6'b011010, 6'b011011: begin
                    m_res  <= div_result(rs_data, rt_data, ~funct[0]);
                    m_left <= W + 1;
                end
`endif
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic         busy_e, cls_e, sel_e;
        logic [W-1:0] rd_e;
        busy_e = (m_left > 0);
        cls_e  = issue_valid && ALUOp == 2'b10 && is_md(funct);
        sel_e  = rst_n && cls_e && !busy_e && (funct == 6'b010000 || funct == 6'b010010);
        rd_e   = !sel_e ? '0 : ((funct == 6'b010000) ? m_hi : m_lo);
        check("cyc_aluctrl", ALUCtrl, rst_n ? exp_alu(ALUOp, funct) : 4'b0000);
        check("cyc_busy", mdu_busy, busy_e);
        check("cyc_stall", md_stall, issue_valid && cls_e && busy_e);
        check("cyc_hilo_sel", hilo_sel, sel_e);
        check("cyc_hilo_rdata", hilo_rdata, rd_e);
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] e;
    } alu_vec_t;

    alu_vec_t vecs [12] = '{
        '{2'b10, 6'b100111, 4'b1100}, '{2'b01, 6'b100111, 4'b0110},
        '{2'b01, 6'b011000, 4'b0110}, '{2'b10, 6'b101011, 4'b0011},
        '{2'b00, 6'b100010, 4'b0010}, '{2'b11, 6'b100000, 4'b0001},
        '{2'b10, 6'b100001, 4'b0010}, '{2'b10, 6'b100011, 4'b0110},
        '{2'b10, 6'b100100, 4'b0000}, '{2'b10, 6'b100101, 4'b0001},
        '{2'b10, 6'b101010, 4'b0111}, '{2'b10, 6'b011000, 4'b0010}
    };

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        issue_valid = v; ALUOp = op; funct = f; rs_data = a; rt_data = b;
    endtask

    task automatic issue(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, 2'b10, f, a, b);
        step();
        drive(1'b0, 2'b10, F_ADD, 32'd0, 32'd0);
        $display("issue %s funct=%b rs=%h rt=%h", name, f, a, b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (mdu_busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy after %0d cycles required=idle", n);
        end
    endtask

    task automatic read_hilo(input string name, input logic [5:0] f, input logic [31:0] exp);
        drive(1'b1, 2'b10, f, 32'd0, 32'd0);
        #1;
        check({name, "_sel"}, hilo_sel, 1'b1);
        check({name, "_stall"}, md_stall, 1'b0);
        check(name, hilo_rdata, exp);
        $display("read %s hilo_rdata=%h expect=%h", name, hilo_rdata, exp);
        step();
        drive(1'b0, 2'b10, F_ADD, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        drive(1'b0, 2'b00, F_ADD, 32'd0, 32'd0);
        repeat (3) step();
        check("rst_aluctrl", ALUCtrl, 4'b0000);
        check("rst_busy", mdu_busy, 1'b0);
        check("rst_rdata", hilo_rdata, 32'd0);
        $display("reset ALUCtrl=%b busy=%b", ALUCtrl, mdu_busy);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].op, vecs[i].f, 32'd0, 32'd0);
            #1;
            check("alu_vec", ALUCtrl, vecs[i].e);
            $display("alu op=%b funct=%b ALUCtrl=%b expect=%b", vecs[i].op, vecs[i].f, ALUCtrl, vecs[i].e);
        end
        step();

        issue("mthi", F_MTHI, 32'h0000_1234, 32'd0);
        read_hilo("mfhi_after_mthi", F_MFHI, 32'h0000_1234);

        // mfhi presented after one busy cycle of the mult
        issue("mult", F_MULT, 32'hFFFF_FFFE, 32'd3);
        step();
        drive(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
        #1;
        n = 0;
        while (md_stall === 1'b1 && n < 100) begin
            n++;
            step();
            #1;
        end
        check("mfhi_stall_cycles", n, 32);
        check("mfhi_after_mult", hilo_rdata, 32'hFFFF_FFFF);
        $display("mfhi stalled %0d cycles hilo_rdata=%h", n, hilo_rdata);
        step();
        drive(1'b0, 2'b10, F_ADD, 32'd0, 32'd0);
        read_hilo("mflo_mult", F_MFLO, 32'hFFFF_FFFA);

        issue("multu", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        read_hilo("mfhi_multu", F_MFHI, 32'hFFFF_FFFE);
        read_hilo("mflo_multu", F_MFLO, 32'h0000_0001);

        issue("mult_extreme", F_MULT, 32'h7FFF_FFFF, 32'h8000_0000);
        wait_idle();
        read_hilo("mfhi_mult_ext", F_MFHI, 32'hC000_0000);
        read_hilo("mflo_mult_ext", F_MFLO, 32'h8000_0000);

`ifdef MDU_DIV_EN
        issue("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_busy", mdu_busy, 1'b1);
        wait_idle();
        read_hilo("mflo_div", F_MFLO, 32'hFFFF_FFFD);
        read_hilo("mfhi_div", F_MFHI, 32'hFFFF_FFFF);

        issue("div_7_m2", F_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle();
        read_hilo("mflo_div_neg_b", F_MFLO, 32'hFFFF_FFFD);
        read_hilo("mfhi_div_neg_b", F_MFHI, 32'h0000_0001);

        issue("divu_7_0", F_DIVU, 32'd7, 32'd0);
        wait_idle();
        read_hilo("mflo_divu0", F_MFLO, 32'hFFFF_FFFF);
        read_hilo("mfhi_divu0", F_MFHI, 32'h0000_0007);

        issue("div_m7_0", F_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_idle();
        read_hilo("mflo_div0", F_MFLO, 32'hFFFF_FFFF);
        read_hilo("mfhi_div0", F_MFHI, 32'hFFFF_FFF9);

        issue("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        read_hilo("mflo_div_ovf", F_MFLO, 32'h8000_0000);
        read_hilo("mfhi_div_ovf", F_MFHI, 32'h0000_0000);
`else
        issue("div_noop", F_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_noop_busy", mdu_busy, 1'b0);
        read_hilo("mfhi_div_noop", F_MFHI, 32'hC000_0000);
        read_hilo("mflo_div_noop", F_MFLO, 32'h8000_0000);
`endif

        // mtlo held while a mult is in flight, accepted on the first idle cycle
        issue("mult_3_5", F_MULT, 32'd3, 32'd5);
        drive(1'b1, 2'b10, F_MTLO, 32'h0000_0055, 32'd0);
        #1;
        n = 0;
        while (md_stall === 1'b1 && n < 100) begin
            n++;
            step();
            #1;
        end
        check("mtlo_stall_cycles", n, 33);
        $display("mtlo stalled %0d cycles", n);
        step();
        drive(1'b0, 2'b10, F_ADD, 32'd0, 32'd0);
        read_hilo("mflo_after_mtlo", F_MFLO, 32'h0000_0055);
        read_hilo("mfhi_mult_3_5", F_MFHI, 32'h0000_0000);

        // reset in the middle of a mult
        issue("mthi", F_MTHI, 32'h0000_ABCD, 32'd0);
        issue("mult_5_5", F_MULT, 32'd5, 32'd5);
        repeat (9) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", mdu_busy, 1'b0);
        $display("reset mid-mult busy=%b", mdu_busy);
        step();
        rst_n = 1'b1;
        step();
        read_hilo("mfhi_after_rst", F_MFHI, 32'h0000_0000);
        read_hilo("mflo_after_rst", F_MFLO, 32'h0000_0000);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
